// File: rtl/h_s_rca_seq_pkg.sv
// Shared definitions for the sequential slice-serial signed adder h_s_rca_seq.
package h_s_rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_W_DEF = 6;
  localparam int CHUNKS_DEF  = 4;

endpackage

// File: rtl/h_s_rca_seq_rca_slice.sv
// Combinational CHUNK_W-bit ripple-carry adder slice; also exposes the carry into its MSB.
module rca_slice
  import h_s_rca_seq_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout,
  output logic               c_msb
);

  logic [CHUNK_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK_W];
  assign c_msb = c[CHUNK_W-1];

endmodule

// File: rtl/h_s_rca_seq.sv
// Slice-serial signed adder: one CHUNK_W-bit slice per RUN cycle, W+1-bit exact sum.
// Define H_S_RCA_SEQ_OVF_EN to add the ovf output (sum does not fit in W bits).
module h_s_rca_seq
  import h_s_rca_seq_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int CHUNKS  = CHUNKS_DEF,
  localparam int W      = CHUNK_W * CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out
`ifdef H_S_RCA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [W:0]         out_q, out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c_msb;

  // Operands shift right each RUN cycle, so the slice always sees the low chunk.
  rca_slice #(.CHUNK_W(CHUNK_W)) u_slice (
    .a     (a_q[CHUNK_W-1:0]),
    .b     (b_q[CHUNK_W-1:0]),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

`ifdef H_S_RCA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef H_S_RCA_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q >> CHUNK_W) | (W'(slice_s) << (W - CHUNK_W));
        a_d     = a_q >> CHUNK_W;
        b_d     = b_q >> CHUNK_W;
        carry_d = slice_cout;
        if (idx_q == IDX_W'(CHUNKS - 1)) begin
          // s_msb ^ c_msb equals a_msb ^ b_msb, so this is the exact sign bit.
          out_d       = {slice_s[CHUNK_W-1] ^ slice_c_msb ^ slice_cout, sum_d};
`ifdef H_S_RCA_SEQ_OVF_EN
          ovf_d       = slice_c_msb ^ slice_cout;
`endif
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          idx_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        idx_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef H_S_RCA_SEQ_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: doc/h_s_rca_seq.md
H_S_RCA_SEQ -- requirements
Module: h_s_rca_seq

Interface
REQ-001 SHALL have parameter CHUNK_W, default 6: width of the shared ripple-carry slice in bits.
REQ-002 SHALL have parameter CHUNKS, default 4: number of slices per operand; W = CHUNK_W*CHUNKS (24 by default).
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: an operand pair is offered.
REQ-006 SHALL have port in_ready  output  1: the block accepts operands this cycle.
REQ-007 SHALL have ports a and b  input  W each: two's-complement signed operands.
REQ-008 SHALL have port out_valid  output  1: the result is available.
REQ-009 SHALL have port out_ready  input  1: the consumer takes the result.
REQ-010 SHALL have port out  output  W+1: signed sum a+b, sign-extended by one bit.

Function
REQ-011 SHALL be an FSM with states IDLE, RUN, DONE.
- IDLE->RUN on in_valid&&in_ready.
- RUN->DONE on the edge that processes slice CHUNKS-1.
- DONE->IDLE on out_valid&&out_ready.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 SHALL latch a and b on the accepting edge and clear the carry flop; later changes on a/b SHALL have no effect on the operation in flight.
REQ-014 SHALL process exactly one slice per RUN cycle, starting at slice index 0 (LSB):
- sum slice = a_slice + b_slice + carry;
- the slice carry-out is registered and used as the carry-in of the next slice.
REQ-015 SHALL, on the final slice, set out[W] = a[W-1] ^ b[W-1] ^ carry-out of bit W-1, so out equals the exact signed sum.
REQ-016 SHALL give a latency of CHUNKS+1 cycles: a handshake in cycle T produces out_valid first in cycle T+CHUNKS+1.
REQ-017 SHALL hold out stable while out_valid=1 and out_ready=0, for an unbounded time.
REQ-018 SHALL keep the slice index in the range 0..CHUNKS-1 and return it to 0 on entering IDLE.
REQ-019 SHALL keep out unchanged after a DONE handshake until the last slice of the next operation overwrites it.
REQ-020 SHALL ignore out_ready outside DONE and ignore in_valid outside IDLE.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, enter IDLE and clear the slice index, carry, out and latched operands to 0.
REQ-022 SHALL drive out_valid=0 and in_ready=1 in the first cycle after reset.
REQ-023 SHALL let rst abort any RUN or DONE operation with no result delivered; rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-024 SHALL, with macro H_S_RCA_SEQ_OVF_EN defined, add output port ovf (1 bit):
- ovf = carry-in of bit W-1 XOR carry-out of bit W-1, i.e. the sum does not fit in W bits;
- ovf is valid and stable under the same rules as out, and resets to 0.
REQ-025 SHALL, without H_S_RCA_SEQ_OVF_EN, have no ovf port and no associated logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the following from package h_s_rca_seq_pkg:
- the FSM state enum (IDLE, RUN, DONE);
- default constants CHUNK_W_DEF=6 and CHUNKS_DEF=4.
REQ-027 SHALL instantiate exactly one sub-module rca_slice, a combinational CHUNK_W-bit ripple-carry adder:
- inputs a, b, cin; outputs s, cout, and c_msb (carry into the slice MSB, used for out[W] and ovf);
- the slice is shared across all RUN cycles.

Verification
REQ-028 SHALL cover sign-extension with a=0xFFFFFF (-1), b=0x000001 -> out=25'h0000000, ovf=0, out_valid in cycle T+5.
REQ-029 SHALL cover positive overflow with a=0x7FFFFF, b=0x000001 -> out=25'h0800000 (+8388608), ovf=1.
REQ-030 SHALL cover negative overflow with a=0x800000, b=0x800000 -> out=25'h1000000 (-16777216), ovf=1.
REQ-031 SHALL cover the full carry chain with a=0x03FFFF, b=0x000001 -> out=25'h0040000, carry crossing three slice boundaries.
REQ-032 SHALL cover backpressure: hold out_ready=0 for 6 cycles in DONE -> out stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-033 SHALL cover reset mid-operation: assert rst in the 2nd RUN cycle -> next cycle IDLE, out=0, out_valid=0; a following a=5, b=-3 -> out=2.
